// File: rtl/mul_div_pkg.sv
// Shared definitions for the M-extension execute units (multiplier and divider).
// Pure declarations: no logic, no latency, no flow control.
package mul_div_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int MUL_ITER     = 32;
    localparam int MUL_CNT_W    = $clog2(MUL_ITER);

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULH   = 2'b01,
        MUL_OP_MULHSU = 2'b10,
        MUL_OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        ADD  = 2'd2
    } mul_state_e;

    function automatic logic mul_rs1_signed(input mul_op_e op);
        return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
    endfunction

endpackage

// File: rtl/csa_nbit.sv
// N-bit 3:2 carry-save compressor; carry output is unshifted (weight of bit i is 2^(i+1)).
// Purely combinational, zero latency, no flow control.
module csa_nbit #(
    parameter int N = 64
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    output logic [N-1:0] sum,
    output logic [N-1:0] carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/mul_seq_ctrl.sv
// Iterative RV32M multiplier: one carry-save step per multiplier bit, then one carry-propagate add.
// Latency 33 cycles from acceptance to o_valid; MUL_EARLY_OUT_EN cuts it to highest set rs2 bit + 2.
// No backpressure: i_start is ignored while busy, o_valid is a one-cycle strobe, i_flush aborts.
module mul_seq_ctrl
    import mul_div_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_flush,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    localparam int AW = 2 * XLEN;
    localparam logic [MUL_CNT_W-1:0] K_LAST = MUL_CNT_W'(MUL_ITER - 1);

    mul_state_e           state_q;
    mul_op_e              op_q;
    logic [AW-1:0]        m_q, s_q, c_q;
    logic [XLEN-1:0]      q_q;
    logic [MUL_CNT_W-1:0] k_q;

    logic [AW-1:0]   m_shift, pp, csa_s, csa_c, sum;
    logic [XLEN-1:0] q_next;
    logic            neg_weight, inject, calc_done;

    always_comb begin
        m_shift    = m_q << k_q;
        // Bit 31 of a signed multiplier carries weight -2^31: add the two's complement of M<<31.
        neg_weight = (k_q == K_LAST) && (op_q == MUL_OP_MULH);
        pp         = '0;
        if (q_q[0]) begin
            pp = neg_weight ? ~m_shift : m_shift;
        end
        inject = neg_weight & q_q[0];
        q_next = q_q >> 1;
        sum    = s_q + c_q;
`ifdef MUL_EARLY_OUT_EN
        calc_done = (k_q == K_LAST) || (q_next == '0);
`else
        calc_done = (k_q == K_LAST);
`endif
    end

    csa_nbit #(.N(AW)) u_csa (
        .a    (s_q),
        .b    (c_q),
        .c    (pp),
        .sum  (csa_s),
        .carry(csa_c)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            op_q     <= MUL_OP_MUL;
            m_q      <= '0;
            s_q      <= '0;
            c_q      <= '0;
            q_q      <= '0;
            k_q      <= '0;
            o_busy   <= 1'b0;
            o_valid  <= 1'b0;
            o_result <= '0;
        end else begin
            o_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start && !i_flush) begin
                        m_q     <= {{XLEN{i_rs1[XLEN-1] & mul_rs1_signed(mul_op_e'(i_op))}}, i_rs1};
                        q_q     <= i_rs2;
                        s_q     <= '0;
                        c_q     <= '0;
                        k_q     <= '0;
                        op_q    <= mul_op_e'(i_op);
                        state_q <= CALC;
                        o_busy  <= 1'b1;
                    end
                end
                CALC: begin
                    if (i_flush) begin
                        state_q <= IDLE;
                        o_busy  <= 1'b0;
                    end else begin
                        s_q <= csa_s;
                        c_q <= (csa_c << 1) | AW'(inject);
                        q_q <= q_next;
                        k_q <= k_q + MUL_CNT_W'(1);
                        if (calc_done) begin
                            state_q <= ADD;
                        end
                    end
                end
                ADD: begin
                    state_q <= IDLE;
                    o_busy  <= 1'b0;
                    if (!i_flush) begin
                        o_result <= (op_q == MUL_OP_MUL) ? sum[XLEN-1:0] : sum[AW-1:XLEN];
                        o_valid  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
